multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit that drives the 16-bit datapath ALU and register file. It accepts one 16-bit instruction per fetch handshake, holds it in an internal instruction register, and sequences FETCH/DECODE/EXEC/MEM/WB. Each step issues the matching alu_op, operand-select, memory and write-back strobes. It sits between instruction memory and the datapath and is the sole issuer of ALU operations.

## Interface
- RETIRE_W, 16, width of retired-instruction counter (wraps modulo 2^RETIRE_W)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  16  instruction word from instruction memory
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  controller accepts instr (FETCH state only)
- mem_ready  in  1  data memory completes the current access
- alu_zero  in  1  ALU result == 0 (datapath-computed)
- alu_op  out  3  001 ADD, 010 SUB, 011 SGE (result FFFF if a>=b else 0000), 000 idle
- alu_src_b  out  1  0 = register rt, 1 = sign-extended immediate
- rs_addr, rt_addr, rd_addr  out  3 each  register addresses from IR
- imm  out  16  IR[5:0] sign-extended
- mem_read, mem_write  out  1 each  data-memory strobes, held until mem_ready
- reg_write  out  1  register-file write enable
- wb_sel  out  1  0 = ALU result, 1 = memory data
- pc_write  out  1  PC update strobe
- pc_src  out  2  00 PC+1, 01 PC+1+imm, 10 IR[11:0] zero-extended
- retired  out  RETIRE_W  count of completed instructions
- halted, illegal  out  1 each  sticky status

## Operation
- Format: opcode IR[15:12], rd IR[11:9], rs IR[8:6], rt IR[5:3]; I-type uses rt field as destination = rd IR[11:9], imm IR[5:0].
- Opcodes: 0000 ADD, 0001 SUB, 0010 SGE (R-type); 0011 ADDI; 0100 LW; 0101 SW; 0110 BEQ; 0111 J; 1111 HALT; all others illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- FETCH: instr_ready=1; on instr_valid, load IR, pulse pc_write with pc_src=00, go to DECODE; otherwise stay.
- DECODE: address/imm outputs valid from IR; HALT opcode -> HALT; illegal -> TRAP; else -> EXEC.
- EXEC: R-type drives its ALU op with alu_src_b=0 and goes to WB. ADDI/LW/SW drive ADD with alu_src_b=1; ADDI -> WB, LW/SW -> MEM. BEQ drives SUB with alu_src_b=0; if alu_zero, pulse pc_write with pc_src=01; -> FETCH. J pulses pc_write with pc_src=10 -> FETCH.
- MEM: alu_op held at ADD, alu_src_b=1. mem_read (LW) or mem_write (SW) stays asserted until the cycle mem_ready=1. LW -> WB; SW -> FETCH.
- WB: one-cycle reg_write=1; wb_sel=1 for LW, else 0; -> FETCH.
- retired increments by 1 on leaving WB, leaving MEM for SW, and leaving EXEC for BEQ/J. It wraps at all-ones to 0. HALT and illegal are not counted.
- HALT: halted=1, all strobes 0, instr_ready=0 until reset. TRAP: same, with illegal=1.

## Timing
- Reset, asynchronous: state=FETCH, IR=0, retired=0. All outputs 0, including instr_ready, alu_op=000, halted and illegal. Strobes drop immediately, even mid-MEM.
- First cycle after rst_n rises: instr_ready=1.
- All control outputs are Moore-decoded from state+IR, except the BEQ pc_write, which also depends on alu_zero in EXEC.
- Latency with zero-wait fetch, in cycles: R-type/ADDI 4, LW 5+Wm, SW 4+Wm, BEQ/J 3. Wm is the number of cycles mem_ready stays low in MEM.
- instr_valid outside FETCH and mem_ready outside MEM are ignored.
- alu_op=000 in every state except EXEC and MEM.

## Test plan
- Reset then ADD r1,r2,r3 (0x0298): instr_ready is 1 in cycle 1; DECODE shows rs=2, rt=3, rd=1; EXEC shows alu_op=001; WB shows reg_write=1 and wb_sel=0; retired=1.
- LW r2,r1,-1 (0x447F) with mem_ready low 3 cycles: imm=0xFFFF, alu_src_b=1; mem_read is held exactly 4 cycles; then WB with wb_sel=1.
- BEQ (0x6005) twice, alu_zero=1 then 0: first pc_write=1 with pc_src=01 in EXEC; second no EXEC pc_write; each takes 3 cycles.
- SGE then J 0x0123 (0x7123): EXEC alu_op=011; J gives pc_src=10 with pc_write; retired advances by 2.
- Opcode 0x8 gives illegal=1; separately, HALT 0xF000 gives halted=1. In both, instr_ready stays 0 and later instr_valid is ignored.
- rst_n low mid-MEM of SW: mem_write drops the same cycle; after release, state is FETCH and retired=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the 16-bit datapath: latches one instruction per fetch
// handshake and sequences FETCH/DECODE/EXEC/MEM/WB, issuing ALU, memory and write-back strobes.
module multicycle_ctrl #(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                mem_ready,
  input  logic                alu_zero,
  output logic [2:0]          alu_op,
  output logic                alu_src_b,
  output logic [2:0]          rs_addr,
  output logic [2:0]          rt_addr,
  output logic [2:0]          rd_addr,
  output logic [15:0]         imm,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                wb_sel,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [RETIRE_W-1:0] retired,
  output logic                halted,
  output logic                illegal
);

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StWb, StHalt, StTrap
  } state_e;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpSge  = 4'h2;
  localparam logic [3:0] OpAddi = 4'h3;
  localparam logic [3:0] OpLw   = 4'h4;
  localparam logic [3:0] OpSw   = 4'h5;
  localparam logic [3:0] OpBeq  = 4'h6;
  localparam logic [3:0] OpJ    = 4'h7;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam logic [2:0] AluIdle = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b001;
  localparam logic [2:0] AluSub  = 3'b010;
  localparam logic [2:0] AluSge  = 3'b011;

  state_e              state_q, state_d;
  logic [15:0]         ir_q, ir_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;
  logic [3:0]          opc;
  logic                is_legal, is_lw, is_sw;

  assign opc      = ir_q[15:12];
  assign is_lw    = (opc == OpLw);
  assign is_sw    = (opc == OpSw);
  assign is_legal = (opc <= OpJ);

  assign rd_addr = ir_q[11:9];
  assign rs_addr = ir_q[8:6];
  assign rt_addr = ir_q[5:3];
  assign imm     = {{10{ir_q[5]}}, ir_q[5:0]};
  assign retired = retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    retire      = 1'b0;
    instr_ready = 1'b0;
    alu_op      = AluIdle;
    alu_src_b   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    halted      = 1'b0;
    illegal     = 1'b0;

    unique case (state_q)
      StFetch: begin
        // FETCH decodes to StFetch during reset, so the handshake is masked by rst_n
        instr_ready = rst_n;
        if (instr_valid && rst_n) begin
          ir_d     = instr;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (opc == OpHalt)  state_d = StHalt;
        else if (!is_legal) state_d = StTrap;
        else                state_d = StExec;
      end
      StExec: begin
        unique case (opc)
          OpAdd: begin alu_op = AluAdd; state_d = StWb; end
          OpSub: begin alu_op = AluSub; state_d = StWb; end
          OpSge: begin alu_op = AluSge; state_d = StWb; end
          OpAddi: begin
            alu_op    = AluAdd;
            alu_src_b = 1'b1;
            state_d   = StWb;
          end
          OpLw, OpSw: begin
            alu_op    = AluAdd;
            alu_src_b = 1'b1;
            state_d   = StMem;
          end
          OpBeq: begin
            alu_op = AluSub;
            if (alu_zero) begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
            end
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpJ: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            retire   = 1'b1;
            state_d  = StFetch;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        alu_op    = AluAdd;
        alu_src_b = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (mem_ready) begin
          retire  = is_sw;
          state_d = is_lw ? StWb : StFetch;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        wb_sel    = is_lw;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StHalt: halted = 1'b1;
      StTrap: illegal = 1'b1;
      default: state_d = StFetch;
    endcase
  end

  assign retired_d = retire ? retired_q + RETIRE_W'(1) : retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed plus random instructions, each checked
// against per-opcode latency, strobe-count and field expectations, with retired tracked by a model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid, instr_ready, mem_ready, alu_zero;
  logic [2:0]  alu_op;
  logic        alu_src_b;
  logic [2:0]  rs_addr, rt_addr, rd_addr;
  logic [15:0] imm;
  logic        mem_read, mem_write, reg_write, wb_sel, pc_write;
  logic [1:0]  pc_src;
  logic [15:0] retired;
  logic        halted, illegal;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_ret;

  multicycle_ctrl #(.RETIRE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .imm(imm), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
    .retired(retired), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rst_ready", 32'(instr_ready), 0);
    chk("rst_aluop", 32'(alu_op), 0);
    chk("rst_strobes", 32'({mem_read, mem_write, reg_write, pc_write, wb_sel, alu_src_b}), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_status", 32'({halted, illegal}), 0);
    chk("rst_fields", 32'({rs_addr, rt_addr, rd_addr, imm}), 0);
    cyc();
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(instr_ready), 1);
    exp_ret = '0;
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic z, input int wm);
    int op, lat, idle, n_alu, n_mr, n_mw, n_rw, n_pw;
    int e_lat, e_alu, e_mr, e_mw, e_rw, e_pw;
    logic [2:0] seen_op, e_op;
    logic seen_srcb, seen_wb, e_srcb, e_wb;
    logic [1:0] seen_src, e_src;
    logic [15:0] e_imm;
    bit done;
    op = int'(ins[15:12]);
    e_imm = {{10{ins[5]}}, ins[5:0]};
    n_alu = 0; n_mr = 0; n_mw = 0; n_rw = 0;
    seen_op = '0; seen_srcb = 1'b0; seen_wb = 1'b0; seen_src = '0;

    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      instr = 16'($urandom); instr_valid = 1'b0; mem_ready = 1'($urandom);
      #1;
      chk("idle_ready", 32'(instr_ready), 1);
      chk("idle_pcw", 32'(pc_write), 0);
      cyc();
    end

    instr = ins; instr_valid = 1'b1; alu_zero = z; mem_ready = (wm == 0);
    #1;
    chk("fetch_ready", 32'(instr_ready), 1);
    chk("fetch_pcw", 32'({pc_write, pc_src}), 32'h4);
    chk("fetch_aluop", 32'(alu_op), 0);
    lat = 1; n_pw = 1;
    cyc();
    instr_valid = 1'b0;
    done = 1'b0;
    while (!done) begin
      instr = 16'($urandom); alu_zero = z; mem_ready = (n_mr + n_mw == wm);
      #1;
      if (instr_ready) begin
        done = 1'b1;
      end else begin
        lat++;
        chk("rs", 32'(rs_addr), 32'(ins[8:6]));
        chk("rt", 32'(rt_addr), 32'(ins[5:3]));
        chk("rd", 32'(rd_addr), 32'(ins[11:9]));
        chk("imm", 32'(imm), 32'(e_imm));
        if (alu_op != 3'b000) begin n_alu++; seen_op = alu_op; seen_srcb = alu_src_b; end
        if (mem_read) n_mr++;
        if (mem_write) n_mw++;
        if (reg_write) begin n_rw++; seen_wb = wb_sel; end
        if (pc_write) begin n_pw++; seen_src = pc_src; end
        if (lat > 40) begin
          $display("FAIL timeout: instr %h still busy after %0d cycles, required return to fetch",
                   ins, lat);
          n_fail++;
          $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
          $fatal(1, "bench aborted");
        end
        cyc();
      end
    end

    e_mr = 0; e_mw = 0; e_rw = 0; e_pw = 1; e_wb = 1'b0; e_srcb = 1'b0; e_src = 2'b00;
    e_op = 3'b001; e_alu = 1; e_lat = 4;
    case (op)
      0, 1, 2: begin e_op = 3'(op + 1); e_rw = 1; end
      3: begin e_srcb = 1'b1; e_rw = 1; end
      4: begin e_srcb = 1'b1; e_lat = 5 + wm; e_alu = wm + 2; e_mr = wm + 1; e_rw = 1;
               e_wb = 1'b1; end
      5: begin e_srcb = 1'b1; e_lat = 4 + wm; e_alu = wm + 2; e_mw = wm + 1; end
      6: begin e_op = 3'b010; e_lat = 3; e_pw = 1 + int'(z); e_src = 2'b01; end
      default: begin e_lat = 3; e_alu = 0; e_pw = 2; e_src = 2'b10; end
    endcase
    exp_ret = exp_ret + 16'd1;

    chk("latency", 32'(lat), 32'(e_lat));
    chk("alu_cycles", 32'(n_alu), 32'(e_alu));
    if (e_alu > 0) begin
      chk("alu_op", 32'(seen_op), 32'(e_op));
      chk("alu_src_b", 32'(seen_srcb), 32'(e_srcb));
    end
    chk("mem_read_cycles", 32'(n_mr), 32'(e_mr));
    chk("mem_write_cycles", 32'(n_mw), 32'(e_mw));
    chk("reg_write_cycles", 32'(n_rw), 32'(e_rw));
    if (e_rw > 0) chk("wb_sel", 32'(seen_wb), 32'(e_wb));
    chk("pc_write_cycles", 32'(n_pw), 32'(e_pw));
    if (e_pw > 1) chk("pc_src", 32'(seen_src), 32'(e_src));
    chk("retired", 32'(retired), 32'(exp_ret));
  endtask

  task automatic run_stop(input logic [15:0] ins, input logic exp_ill);
    instr = ins; instr_valid = 1'b1; mem_ready = 1'b0;
    #1;
    chk("stop_fetch_ready", 32'(instr_ready), 1);
    cyc();
    for (int i = 0; i < 6; i++) begin
      instr = {4'h0, 12'($urandom)}; instr_valid = 1'b1; mem_ready = 1'($urandom);
      alu_zero = 1'($urandom);
      #1;
      chk("stop_ready", 32'(instr_ready), 0);
      chk("stop_strobes", 32'({alu_op, mem_read, mem_write, reg_write, pc_write}), 0);
      chk("stop_halted", 32'(halted), 32'((i >= 1) && !exp_ill));
      chk("stop_illegal", 32'(illegal), 32'((i >= 1) && exp_ill));
      cyc();
    end
    instr_valid = 1'b0;
    chk("stop_retired", 32'(retired), 32'(exp_ret));
  endtask

  initial begin
    logic [15:0] ins;
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
    exp_ret = '0;
    cyc();
    do_reset();

    run_instr(16'h0298, 1'b0, 0);
    run_instr(16'h447F, 1'b0, 3);
    run_instr(16'h6005, 1'b1, 0);
    run_instr(16'h6005, 1'b0, 0);
    run_instr(16'h2298, 1'b1, 0);
    run_instr(16'h7123, 1'b0, 0);
    run_instr(16'h5A4C, 1'b0, 2);

    // SW stalled in MEM, then reset asserted mid-access
    instr = 16'h5283; instr_valid = 1'b1; mem_ready = 1'b0;
    #1;
    cyc();
    instr_valid = 1'b0;
    cyc();
    cyc();
    #1;
    chk("midmem_write_before", 32'(mem_write), 1);
    rst_n = 1'b0;
    #1;
    chk("midmem_write_drop", 32'(mem_write), 0);
    chk("midmem_retired", 32'(retired), 0);
    chk("midmem_ready", 32'(instr_ready), 0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("midmem_post_ready", 32'(instr_ready), 1);
    chk("midmem_post_retired", 32'(retired), 0);
    exp_ret = '0;

    for (int k = 0; k < 40; k++) begin
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 7));
      run_instr(ins, 1'($urandom), $urandom_range(0, 4));
    end

    run_stop(16'h8000, 1'b1);
    do_reset();
    run_stop(16'hF000, 1'b0);
    do_reset();
    run_instr(16'h3A7F, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
